// File: rtl/sorted_stream_tx.sv
// sorted_stream_tx: captures the sorter result on R_I rise and streams it ascending over valid/ready, flagging order violations
module sorted_stream_tx #(
    parameter int max_size = 16,
    parameter int bit_size = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [bit_size-1:0]          n,
    input  logic [bit_size*max_size-1:0] dataIn,
    input  logic                         R_I,
    output logic [bit_size-1:0]          dataOut,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic                         last,
    output logic                         busy,
    output logic                         done,
    output logic                         order_err
);
    localparam int aw = max_size > 1 ? $clog2(max_size) : 1;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;
    state_t state;
    logic [bit_size-1:0] mem [max_size];
    logic [bit_size-1:0] slot [max_size];
    logic [bit_size-1:0] idx, prev, cnt, cnt_m1, nxt;
    logic R_I_d, first;
    for (genvar i = 0; i < max_size; i++) begin : g_slot
        assign slot[i] = dataIn[i*bit_size +: bit_size];
    end
    always_comb begin
        cnt = (n > bit_size'(max_size)) ? bit_size'(max_size) : n;
        cnt_m1 = cnt - bit_size'(1);
        nxt = idx - bit_size'(1);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            for (int k = 0; k < max_size; k++) mem[k] <= '0;
            idx <= '0;
            prev <= '0;
            first <= 1'b0;
            R_I_d <= 1'b0;
            dataOut <= '0;
            valid_out <= 1'b0;
            last <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            order_err <= 1'b0;
        end else begin
            R_I_d <= R_I;
            case (state)
                S_IDLE: if (R_I && !R_I_d) begin
                    for (int k = 0; k < max_size; k++) mem[k] <= slot[k];
                    if (cnt == '0) begin
                        state <= S_DONE;
                        done <= 1'b1;
                    end else begin
                        state <= S_SEND;
                        idx <= cnt_m1;
                        first <= 1'b1;
                        order_err <= 1'b0;
                        dataOut <= slot[cnt_m1[aw-1:0]];
                        last <= (cnt_m1 == '0);
                        valid_out <= 1'b1;
                        busy <= 1'b1;
                    end
                end
                S_SEND: if (ready_in) begin
                    if (!first && dataOut < prev) order_err <= 1'b1;
                    prev <= dataOut;
                    first <= 1'b0;
                    if (idx == '0) begin
                        state <= S_DONE;
                        valid_out <= 1'b0;
                        last <= 1'b0;
                        busy <= 1'b0;
                        done <= 1'b1;
                        dataOut <= '0;
                    end else begin
                        idx <= nxt;
                        dataOut <= mem[nxt[aw-1:0]];
                        last <= (nxt == '0);
                    end
                end
                default: if (!R_I) begin
                    state <= S_IDLE;
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sorted_stream_tx.sv
// tb_sorted_stream_tx: directed scoreboard bench for sorted_stream_tx
module tb_sorted_stream_tx;
    logic clk = 1'b0, reset = 1'b0, R_I = 1'b0, ready_in = 1'b0;
    logic [15:0] n = '0;
    logic [255:0] dataIn = '0;
    logic [15:0] dataOut;
    logic valid_out, last, busy, done, order_err;
    int checks = 0, errors = 0, xfers = 0, vcount = 0, cyc;
    logic [16:0] q[$];
    logic stall_prev = 1'b0;
    logic [15:0] held = '0;
    logic [16:0] exp_w;
    sorted_stream_tx dut (
        .clk(clk), .reset(reset), .n(n), .dataIn(dataIn), .R_I(R_I),
        .dataOut(dataOut), .valid_out(valid_out), .ready_in(ready_in),
        .last(last), .busy(busy), .done(done), .order_err(order_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #2;
    endtask
    task automatic wait_done(input int budget, output int c);
        for (c = 1; c <= budget; c++) begin
            tick();
            if (done) break;
        end
    endtask
    task automatic push(input logic [15:0] d, input logic l);
        q.push_back({l, d});
    endtask
    task automatic set_slot(input int k, input logic [15:0] v);
        dataIn[k*16 +: 16] = v;
    endtask
    always @(negedge clk) begin
        if (valid_out) vcount++;
        if (stall_prev && valid_out) chk("stall_hold", dataOut, held);
        if (valid_out && ready_in) begin
            xfers++;
            if (q.size() == 0) chk("unexpected_word", {15'd0, last, dataOut}, 32'hFFFF_FFFF);
            else begin
                exp_w = q.pop_front();
                chk("word", {last, dataOut}, exp_w);
            end
        end
        stall_prev = valid_out && !ready_in;
        held = dataOut;
    end
    initial begin
        logic pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        #3;
        chk("reset_outputs", {dataOut, valid_out, last, busy, done, order_err}, 0);
        tick();
        reset = 1'b1;
        tick();
        // basic stream
        n = 4;
        set_slot(3, 2); set_slot(2, 5); set_slot(1, 5); set_slot(0, 9);
        push(2, 0); push(5, 0); push(5, 0); push(9, 1);
        ready_in = 1'b1; xfers = 0; R_I = 1'b1;
        wait_done(20, cyc);
        chk("basic_latency", cyc, 5);
        chk("basic_xfers", xfers, 4);
        chk("basic_order_err", order_err, 0);
        chk("basic_queue", q.size(), 0);
        R_I = 1'b0;
        tick();
        chk("basic_done_clear", done, 0);
        // backpressure
        push(2, 0); push(5, 0); push(5, 0); push(9, 1);
        ready_in = 1'b0; xfers = 0; R_I = 1'b1;
        tick();
        chk("bp_valid", valid_out, 1);
        foreach (pat[k]) begin
            ready_in = pat[k];
            tick();
        end
        ready_in = 1'b1;
        wait_done(20, cyc);
        chk("bp_xfers", xfers, 4);
        chk("bp_queue", q.size(), 0);
        R_I = 1'b0;
        tick();
        // n = 0
        n = 0; vcount = 0; R_I = 1'b1;
        tick();
        chk("n0_done", done, 1);
        tick();
        chk("n0_valid", {valid_out, 8'(vcount)}, 0);
        R_I = 1'b0;
        tick();
        // n clamped to max_size
        for (int k = 0; k < 16; k++) set_slot(k, 16'(240 - 16 * k));
        for (int k = 15; k >= 0; k--) push(16'(240 - 16 * k), k == 0);
        n = 20; xfers = 0; R_I = 1'b1;
        wait_done(40, cyc);
        chk("clamp_latency", cyc, 17);
        chk("clamp_xfers", xfers, 16);
        chk("clamp_order_err", order_err, 0);
        chk("clamp_queue", q.size(), 0);
        R_I = 1'b0;
        tick();
        // reset mid-stream
        n = 8;
        for (int k = 0; k < 8; k++) set_slot(k, 16'(20 - k));
        for (int k = 7; k >= 0; k--) push(16'(20 - k), k == 0);
        xfers = 0; R_I = 1'b1;
        for (int k = 0; k < 20 && xfers < 3; k++) tick();
        chk("rst_pre_xfers", xfers, 3);
        reset = 1'b0;
        #1;
        chk("rst_outputs", {dataOut, valid_out, last, busy, done, order_err}, 0);
        q.delete();
        for (int k = 7; k >= 0; k--) push(16'(20 - k), k == 0);
        xfers = 0;
        tick();
        reset = 1'b1;
        wait_done(20, cyc);
        chk("rst_latency", cyc, 9);
        chk("rst_xfers", xfers, 8);
        chk("rst_queue", q.size(), 0);
        R_I = 1'b0;
        tick();
        // order violation
        n = 3;
        set_slot(2, 7); set_slot(1, 3); set_slot(0, 8);
        push(7, 0); push(3, 0); push(8, 1);
        xfers = 0; R_I = 1'b1;
        wait_done(20, cyc);
        chk("ord_done", done, 1);
        chk("ord_xfers", xfers, 3);
        chk("ord_err", order_err, 1);
        // re-arm with a rise during SEND that must be ignored
        R_I = 1'b0;
        tick();
        chk("rearm_done_clear", done, 0);
        chk("rearm_err_hold", order_err, 1);
        n = 2;
        set_slot(1, 1); set_slot(0, 4);
        push(1, 0); push(4, 1);
        ready_in = 1'b0; xfers = 0; R_I = 1'b1;
        tick();
        chk("rearm_err_clear", order_err, 0);
        chk("rearm_busy", busy, 1);
        R_I = 1'b0; n = 5;
        set_slot(1, 16'hFFFF); set_slot(0, 0);
        tick();
        R_I = 1'b1;
        tick();
        tick();
        chk("rearm_held_word", dataOut, 1);
        ready_in = 1'b1;
        wait_done(20, cyc);
        chk("rearm_xfers", xfers, 2);
        chk("rearm_queue", q.size(), 0);
        chk("rearm_order_err", order_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
